// File: rtl/tree_update_ctrl_pkg.sv
// Shared definitions for the tree node-RAM update controller: header layout,
// opcode, FSM encoding and the node word width used by the tree levels.
package tree_update_ctrl_pkg;

    // Node word width shared with the tree level modules.
    localparam int node_width_default = 16;

    // Only block writes are recognised.
    localparam logic [3:0] opc_block_write = 4'hA;

    // Header word layout: [31:28] opcode, [27:24] level, [23:12] start, [11:0] count-1.
    typedef struct packed {
        logic [3:0]  opcode;
        logic [3:0]  level;
        logic [11:0] start;
        logic [11:0] count;
    } header_t;

    typedef enum logic [1:0] {
        st_idle  = 2'd0,
        st_drain = 2'd1,
        st_write = 2'd2,
        st_done  = 2'd3
    } state_t;

    // A header is usable when it is a block write to an existing level and the
    // whole block (start .. start+count) lies inside that level's 2^L nodes.
    // The end address is formed in 13 bits so it can never wrap.
    function automatic logic header_ok(input header_t h, input int unsigned levels);
        logic [12:0] block_end;
        logic [12:0] level_size;
        block_end  = {1'b0, h.start} + {1'b0, h.count} + 13'd1;
        level_size = 13'd1 << h.level;
        if (h.opcode != opc_block_write) return 1'b0;
        if ({28'd0, h.level} >= levels)  return 1'b0;
        return block_end <= level_size;
    endfunction

endpackage

// File: rtl/tree_update_ctrl.sv
// Tree update controller: takes a block-write header from the config stream,
// gates new lookups, waits for the pipeline to drain, then streams node words
// into the selected level's RAM before reopening the lookup path.
module tree_update_ctrl
    import tree_update_ctrl_pkg::*;
#(
    parameter int total_level  = 12,
    parameter int node_width   = node_width_default,
    parameter int drain_cycles = total_level
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            cfg_data_in,
    input  logic                   cfg_valid_in,
    output logic                   cfg_ready_out,
    input  logic                   lookup_valid_in,
    output logic                   lookup_valid_out,
    output logic                   lookup_stall_out,
    output logic [total_level-1:0] wr_en_out,
    output logic [total_level-2:0] wr_addr_out,
    output logic [node_width-1:0]  wr_data_out,
    output logic                   update_done_out,
    output logic                   err_out
);

    localparam int addr_w = total_level - 1;
    localparam int cnt_w  = $clog2(drain_cycles + 2);

    state_t                 state_q, state_d;
    header_t                hdr;
    logic                   hdr_ok;
    logic                   accept;
    logic [3:0]             level_q;
    logic [addr_w-1:0]      addr_q;
    logic [11:0]            remain_q;
    logic [cnt_w-1:0]       drain_q;
    logic [total_level-1:0] wr_en_q;
    logic [addr_w-1:0]      wr_addr_q;
    logic [node_width-1:0]  wr_data_q;
    logic                   err_q;

    assign hdr    = header_t'(cfg_data_in);
    assign hdr_ok = header_ok(hdr, total_level);
    assign accept = cfg_valid_in & cfg_ready_out;

    // Stall covers DRAIN, WRITE and DONE; it follows the registered state so it
    // drops the moment reset lands.
    assign lookup_stall_out = (state_q != st_idle);
    assign lookup_valid_out = lookup_valid_in & ~lookup_stall_out;
    assign cfg_ready_out    = (state_q == st_idle) || (state_q == st_write);
    assign update_done_out  = (state_q == st_done);
    assign wr_en_out        = wr_en_q;
    assign wr_addr_out      = wr_addr_q;
    assign wr_data_out      = wr_data_q;
    assign err_out          = err_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples
        // pre-edge values regardless of block ordering.
        if (rst) state_q <= st_idle;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            st_idle:  if (accept && hdr_ok)          state_d = st_drain;
            st_drain: if (drain_q <= cnt_w'(1))      state_d = st_write;
            st_write: if (accept && remain_q == '0)  state_d = st_done;
            st_done:                                 state_d = st_idle;
            default:                                 state_d = st_idle;
        endcase
    end

    // Header latch, drain/word counters and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= '0;
            addr_q    <= '0;
            remain_q  <= '0;
            drain_q   <= '0;
            wr_en_q   <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= '0;
            err_q   <= (state_q == st_idle) && accept && !hdr_ok;

            if (state_q == st_idle && accept && hdr_ok) begin
                level_q  <= hdr.level;
                addr_q   <= hdr.start[addr_w-1:0];
                remain_q <= hdr.count;
                drain_q  <= cnt_w'(drain_cycles);
            end

            if (state_q == st_drain && drain_q != '0)
                drain_q <= drain_q - cnt_w'(1);

            // Every accepted word in WRITE is data; headers are never decoded here.
            if (state_q == st_write && accept) begin
                wr_en_q   <= total_level'(1) << level_q;
                wr_addr_q <= addr_q;
                wr_data_q <= cfg_data_in[node_width-1:0];
                addr_q    <= addr_q + addr_w'(1);
                if (remain_q != '0) remain_q <= remain_q - 12'd1;
            end
        end
    end

endmodule

// File: doc/tree_update_ctrl.md
TREE_UPDATE_CTRL -- requirements
Module: tree_update_ctrl

Interface
REQ-001 Parameters, one per line: total_level, 12, pipeline depth and number of node RAMs (levels 0..total_level-1); node_width, 16, bits per node word; drain_cycles, total_level, idle cycles between lookup gating and the first write.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 cfg_data_in  input  32  configuration stream word (header or node data).
REQ-005 cfg_valid_in  input  1  cfg_data_in valid.
REQ-006 cfg_ready_out  output  1  word accepted when cfg_valid_in & cfg_ready_out.
REQ-007 lookup_valid_in  input  1  upstream key valid.
REQ-008 lookup_valid_out  output  1  gated key valid into the tree pipeline.
REQ-009 lookup_stall_out  output  1  upstream holds Key/valid while high.
REQ-010 wr_en_out  output  total_level  one-hot per-level node RAM write enable.
REQ-011 wr_addr_out  output  total_level-1  node address within the selected level.
REQ-012 wr_data_out  output  node_width  node word written.
REQ-013 update_done_out  output  1  one-cycle pulse at update completion.
REQ-014 err_out  output  1  one-cycle pulse on a rejected header.

Function
REQ-015 Header format: [31:28] opcode (4'hA = block write), [27:24] level L, [23:12] start address S, [11:0] count-1 N.
REQ-016 Data word: node value in [node_width-1:0]; upper bits ignored.
REQ-017 FSM states: IDLE, DRAIN, WRITE, DONE; reset state IDLE.
REQ-018 IDLE: cfg_ready_out=1; accepted header is checked in the same cycle.
REQ-019 Header rejected if opcode != 4'hA, L >= total_level, or S+N+1 > 2^L (13-bit unsigned sum, no wrap); rejection pulses err_out the next cycle, FSM stays IDLE, stall never asserts.
REQ-020 Valid header: latch L, S, N; next cycle lookup_stall_out=1 and FSM enters DRAIN with counter loaded to drain_cycles.
REQ-021 lookup_valid_out = lookup_valid_in & ~lookup_stall_out (combinational); a valid arriving in the cycle stall rises is blocked.
REQ-022 DRAIN: cfg_ready_out=0; counter decrements each cycle; at 0, FSM enters WRITE.
REQ-023 WRITE: cfg_ready_out=1; each accepted word drives wr_en_out[L]=1, wr_addr_out=current address, wr_data_out=word, registered (1-cycle latency from acceptance); address starts at S and increments by 1; no write on a cycle without acceptance.
REQ-024 After N+1 accepted words FSM enters DONE; cfg_ready_out=0 in DONE.
REQ-025 DONE (one cycle): update_done_out=1, lookup_stall_out deasserts at the end of the cycle; FSM returns to IDLE.
REQ-026 Count N=0 (single word) and level 0 (S=0, N=0 only) are legal.
REQ-027 Headers are never interpreted while in WRITE; every accepted word there is data.
REQ-028 At most one wr_en_out bit high in any cycle; all zero outside WRITE-driven cycles.

Reset
REQ-029 Asynchronous rst: FSM=IDLE, lookup_stall_out=0, wr_en_out=0, wr_addr_out=0, wr_data_out=0, update_done_out=0, err_out=0, counters=0; cfg_ready_out=1 after release.
REQ-030 Reset mid-DRAIN or mid-WRITE abandons the update; stall releases immediately; no further writes.

Structure
REQ-031 Shared package holds opcode constant 4'hA, header field positions, FSM state encoding and node_width default; tree level modules use the same node_width.
REQ-032 Single module; no sub-module required (header checker inline).

Verification
REQ-033 Header 0xA3_004_003 then words 0x11,0x22,0x33,0x44 -> stall high, 12 drain cycles, writes on wr_en_out[3] addr 4..7 data 0x11..0x44, done pulse, stall low.
REQ-034 Header with level 12 or opcode 0x5 -> err_out pulse, no stall, no write, cfg_ready_out stays 1.
REQ-035 Header L=2, S=3, N=1 (overflow past 4 nodes) -> err_out pulse, no writes.
REQ-036 lookup_valid_in held high across update -> lookup_valid_out low from the first stall cycle through DONE, high again the cycle after.
REQ-037 cfg_valid_in toggled 1-0-1 during WRITE -> writes only on accepted cycles, addresses contiguous.
REQ-038 rst asserted after 2 of 4 data words -> outputs reset asynchronously, exactly 2 writes observed, next header processed normally.
